// File: rtl/twos_complement_divider.sv
`timescale 1ns/1ps
// Sequential signed divider: restoring division on sign magnitudes, C-style
// truncation, one conditional subtract per cycle on a single add/sub datapath.
module twos_complement_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             dz,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_W1   = (WIDTH+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             zero_q, zero_d;
  logic             ovf_cond_q, ovf_cond_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  // Trial subtract: shifted partial remainder minus {0,|divisor|}, done as an
  // add of the inverted divisor with carry-in 1. MSB set means it went negative.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  assign shifted = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial   = shifted + {1'b1, ~dvs_mag_q} + ONE_W1;

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

  // Next-state and datapath: everything holds unless the current state updates it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    q_d        = q_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    dvs_mag_d  = dvs_mag_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    zero_d     = zero_q;
    ovf_cond_d = ovf_cond_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
        q_d        = dvd_q[WIDTH-1] ? (~dvd_q + ONE_W) : dvd_q;
        dvs_mag_d  = dvs_q[WIDTH-1] ? (~dvs_q + ONE_W) : dvs_q;
        sign_a_d   = dvd_q[WIDTH-1];
        sign_b_d   = dvs_q[WIDTH-1];
        zero_d     = (dvs_q == '0);
        ovf_cond_d = (dvd_q == MOST_NEG) && (dvs_q == '1);
        p_d        = '0;
        cnt_d      = '0;
        state_d    = S_DIV;
      end
      S_DIV: begin
        if (!trial[WIDTH]) begin
          p_d = trial;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          p_d = shifted;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        // Overflow needs no special datapath: |q| = 2^(WIDTH-1) wraps to MOST_NEG.
        if (zero_q) begin
          quot_d = '1;
          rem_d  = dvd_q;
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          quot_d = (sign_a_q ^ sign_b_q) ? (~q_q + ONE_W) : q_q;
          rem_d  = sign_a_q ? (~p_q[WIDTH-1:0] + ONE_W) : p_q[WIDTH-1:0];
          dz_d   = 1'b0;
          ovf_d  = ovf_cond_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      q_q        <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      dvs_mag_q  <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      zero_q     <= 1'b0;
      ovf_cond_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      q_q        <= q_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      dvs_mag_q  <= dvs_mag_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      zero_q     <= zero_d;
      ovf_cond_q <= ovf_cond_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: doc/twos_complement_divider.md
# twos_complement_divider

Sequential signed divider: the inverse operation to the team's ripple two's complement adder/subtractor. It takes a two's complement dividend and divisor and computes the quotient and remainder by restoring division. Each iteration is one conditional subtract on a single add/sub datapath (invert-and-carry-in subtraction). It sits beside the adder in the arithmetic library and serves control logic that needs occasional division without a combinational array.

## Interface

**Parameters**
- WIDTH, default 4: operand, quotient and remainder width in bits (two's complement). Must be ≥ 2.

**Ports**
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted on a rising edge when start=1 and ready=1.
- ready  output  1  high only in IDLE.
- dividend  input  WIDTH  two's complement dividend; sampled at acceptance.
- divisor  input  WIDTH  two's complement divisor; sampled at acceptance.
- quotient  output  WIDTH  two's complement quotient; held until the next acceptance.
- remainder  output  WIDTH  two's complement remainder; held until the next acceptance.
- done  output  1  one-cycle pulse; results are valid in this cycle and afterwards.
- dz  output  1  divide-by-zero flag; valid with done and held with the results.
- ovf  output  1  overflow flag (most-negative / −1); valid with done and held with the results.

## Operation

- **Division semantics:** truncating division, as in C.
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder sign follows the dividend.
  - dividend = quotient·divisor + remainder.
  - |remainder| < |divisor|.
- **FSM:** IDLE → PREP → DIV (exactly WIDTH cycles, counter 0..WIDTH−1) → FIX → DONE → IDLE.
- **IDLE:** ready=1. On acceptance, register the operands and go to PREP.
- **PREP:**
  - Form WIDTH-bit unsigned magnitudes. Negation is ~x+1. The most-negative value maps to 2^(WIDTH−1).
  - Latch both sign bits and the zero-divisor condition.
  - Clear the partial remainder P (WIDTH+1 bits). Load shift register Q with |dividend|.
- **DIV:** each cycle:
  - T = {P[WIDTH−1:0], Q[WIDTH−1]} − {0,|divisor|}, computed as an add with the divisor inverted and carry-in 1.
  - If T is non-negative (MSB=0): P←T and Q←{Q[WIDTH−2:0],1}.
  - Otherwise: P←{P[WIDTH−1:0],Q[WIDTH−1]} and Q←{Q[WIDTH−2:0],0}.
- **FIX:** apply the signs and register the outputs.
  - quotient = Q, negated if the signs differ.
  - remainder = P[WIDTH−1:0], negated if the dividend is negative.
- **Divide by zero** (divisor=0):
  - The same FSM path and latency are used; DIV results are discarded.
  - FIX sets quotient = all ones, remainder = dividend, dz=1, ovf=0.
- **Overflow** (dividend = −2^(WIDTH−1) and divisor = −1):
  - quotient = −2^(WIDTH−1) (wrapped bit pattern), remainder = 0, ovf=1, dz=0.
- **Flags:** dz and ovf are updated in FIX only.
- **Ignored requests:** start while not in IDLE is ignored. It is not queued, and the operands are not resampled.

## Timing

- **Reset:** asserting rst_n=0 at any time, including mid-DIV, immediately gives:
  - state=IDLE, ready=1;
  - quotient=0, remainder=0;
  - done=0, dz=0, ovf=0;
  - P, Q and the counter cleared.
  - An aborted operation never produces done.
- **Latency:**
  - Acceptance edge E0.
  - PREP after E0; DIV after E1..E(WIDTH).
  - FIX after E(WIDTH+1); DONE after E(WIDTH+2).
  - done=1 for exactly the cycle following E(WIDTH+2). For WIDTH=4 that is 6 edges after acceptance.
- **Throughput:**
  - ready returns to 1 on the edge after DONE.
  - Minimum spacing between acceptances is WIDTH+4 edges.
  - start held high continuously produces back-to-back operations at that spacing.
- **Output stability:** results and flags change only on the FIX→DONE edge. They are stable from the done cycle until the next operation's FIX.
- **Fixed latency:** latency is independent of operand values, including zero and overflow cases.

## Test plan

All cases use WIDTH=4.

- **Sign combinations:**
  - 7/2 → q=3 (0011), r=1, dz=0, ovf=0.
  - −7/2 → q=1101 (−3), r=1111 (−1).
  - 7/−2 → q=1101, r=0001.
  - −8/3 → q=1110 (−2), r=1110 (−2).
  - done occurs exactly 6 edges after acceptance for every case.
- **Boundaries:**
  - −8/−1 → q=1000, r=0000, ovf=1, dz=0.
  - −8/1 → q=1000, r=0, ovf=0.
  - 3/5 → q=0, r=3.
  - −1/−1 → q=1, r=0.
- **Divide by zero:** 5/0 → q=1111, r=0101, dz=1, ovf=0, with the same 6-edge latency. The following 6/3 → q=2, r=0, dz=0.
- **Handshake:**
  - start pulses during PREP/DIV/FIX with different operands → ignored. The first result is unchanged, and ready=0 until after DONE.
  - start held high gives acceptances spaced 8 edges apart.
- **Reset:**
  - rst_n deasserted-then-asserted mid-DIV (third iteration) → outputs go to 0 and ready goes to 1 immediately, with no done.
  - A new 6/4 afterwards → q=1, r=2.
- **Exhaustive sweep:** all 256 operand pairs, compared against a reference model using truncating semantics and the dz/ovf rules above.
